// File: rtl/maria_reg_loader_if.sv
// ---------------------------------------------------------------------------
// maria_reg_loader_if
//
// Bus bundle between the MARIA register loader and the MARIA register
// decoder / CPU bus it borrows.
//
// Signals:
//   pclk0    - one-sysclock processor-phase strobe; the bus advances on it
//   ready    - CPU ready line, released by MARIA at the end of a line
//   AB       - 16-bit address driven while the loader owns the bus
//   DB_out   - 8-bit write data
//   we_b     - active-low write strobe
//   drive_AB - loader owns the bus (CPU is held off the address bus)
//
// Modports:
//   master - the loader: samples pclk0/ready, drives the bus
//   slave  - the bus side: supplies pclk0/ready, observes the bus
// ---------------------------------------------------------------------------
interface maria_reg_loader_if;
  logic        pclk0;
  logic        ready;
  logic [15:0] AB;
  logic [7:0]  DB_out;
  logic        we_b;
  logic        drive_AB;

  modport master (
    input  pclk0,
    input  ready,
    output AB,
    output DB_out,
    output we_b,
    output drive_AB
  );

  modport slave (
    output pclk0,
    output ready,
    input  AB,
    input  DB_out,
    input  we_b,
    input  drive_AB
  );
endinterface

// File: rtl/maria_reg_loader.sv
// ---------------------------------------------------------------------------
// maria_reg_loader
//
// Bus initiator that programs the MARIA register file from a parallel
// register image, without CPU involvement (BIOS-skip boot, savestate
// restore). On start it snapshots the image, takes the bus, issues one
// register write per pclk0 strobe with CTRL written last, and releases
// the bus again.
//
// Optional feature macro: MARIA_LOADER_WSYNC_EN
//   When defined, a WSYNC write (0x24) follows CTRL and the loader keeps the
//   bus until ready returns high, so the caller resumes on a line boundary.
//   When undefined, the SYNC/WAIT states do not exist and ready is unused.
//
// Ports:
//   sysclock      in  - system clock, all state changes on its rising edge
//   reset         in  - synchronous, active-high reset
//   start         in  - begin a load (sampled only while idle)
//   img_color     in  - 25 color registers, index 0 is background
//   img_zp        in  - display list list pointer {ZPH, ZPL}
//   img_char_base in  - CHARBASE value
//   img_ctrl      in  - CTRL value
//   busy          out - high from accept through completion
//   done          out - one-sysclock pulse on completion
//   bus           master modport of maria_reg_loader_if
//                 (pclk0, ready in; AB, DB_out, we_b, drive_AB out)
// ---------------------------------------------------------------------------
module maria_reg_loader (
  input  logic              sysclock,
  input  logic              reset,
  input  logic              start,
  input  logic [24:0][7:0]  img_color,
  input  logic [15:0]       img_zp,
  input  logic [7:0]        img_char_base,
  input  logic [7:0]        img_ctrl,
  output logic              busy,
  output logic              done,
  maria_reg_loader_if.master bus
);

  localparam int         NUM_ITEMS = 29;
  localparam logic [4:0] LAST_IDX  = 5'd28;
  localparam logic [7:0] WSYNC_ADDR = 8'h24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LOAD,
`ifdef MARIA_LOADER_WSYNC_EN
    S_SYNC,
    S_WAIT,
`endif
    S_REL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  idx;
  logic [4:0]  idx_nxt;

  // Image reordered into write order, and the snapshot taken from it.
  logic [7:0]  items [NUM_ITEMS];
  logic [7:0]  snap  [NUM_ITEMS];

  // Registered bus drivers; the bus only ever sees flop outputs.
  logic [7:0]  ab_q;
  logic [7:0]  ab_nxt;
  logic [7:0]  db_q;
  logic [7:0]  db_nxt;
  logic        we_b_q;
  logic        we_b_nxt;
  logic        drive_q;
  logic        drive_nxt;
  logic        done_q;
  logic        done_nxt;

  logic        pclk0;
  logic        accept;

  assign pclk0  = bus.pclk0;
  assign accept = (state == S_IDLE) && start;

`ifndef MARIA_LOADER_WSYNC_EN
  // Without the WSYNC tail the ready line has no meaning to this block.
  logic unused_ready;
  assign unused_ready = bus.ready;
`endif

  // Register address for write-order item i. The MARIA map leaves holes at
  // 0x24 (WSYNC) and 0x28 (MSTAT-style read-only), and CTRL at 0x3C is moved
  // to the end so the display is only re-enabled once everything else is set.
  function automatic logic [7:0] item_addr(input logic [4:0] i);
    logic [7:0] w;
    w = {3'b000, i};
    if (i <= 5'd3)       return 8'h20 + w;
    else if (i <= 5'd6)  return 8'h21 + w;
    else if (i <= 5'd9)  return 8'h22 + w;
    else if (i == 5'd10) return 8'h2C;
    else if (i <= 5'd13) return 8'h22 + w;
    else if (i == 5'd14) return 8'h30;
    else if (i <= 5'd17) return 8'h22 + w;
    else if (i == 5'd18) return 8'h34;
    else if (i <= 5'd21) return 8'h22 + w;
    else if (i <= 5'd24) return 8'h23 + w;
    else if (i <= 5'd27) return 8'h24 + w;
    else                 return 8'h3C;
  endfunction

  // Rearrange the parallel image into the order the writes are issued, so
  // the snapshot can be indexed directly by the item counter.
  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) items[k] = 8'h00;
    for (int k = 0; k <= 9; k++)   items[k]     = img_color[k];
    items[10] = img_zp[15:8];
    for (int k = 10; k <= 12; k++) items[k + 1] = img_color[k];
    items[14] = img_zp[7:0];
    for (int k = 13; k <= 15; k++) items[k + 2] = img_color[k];
    items[18] = img_char_base;
    for (int k = 16; k <= 24; k++) items[k + 3] = img_color[k];
    items[28] = img_ctrl;
  end

  // Snapshot on accept. Deliberately not reset: a reset mid-load leaves the
  // last accepted image in place, which is harmless and saves a wide clear.
  always_ff @(posedge sysclock) begin
    if (!reset && accept) begin
      for (int k = 0; k < NUM_ITEMS; k++) snap[k] <= items[k];
    end
  end

  // State register, item counter and registered bus outputs.
  always_ff @(posedge sysclock) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= 5'd0;
      ab_q    <= 8'h00;
      db_q    <= 8'h00;
      we_b_q  <= 1'b1;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      ab_q    <= ab_nxt;
      db_q    <= db_nxt;
      we_b_q  <= we_b_nxt;
      drive_q <= drive_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state logic. Everything except leaving IDLE and leaving WAIT is
  // paced by pclk0, so the decoder sees each item for a full strobe period.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ARM;
          idx_nxt   = 5'd0;
        end
      end
      S_ARM: begin
        if (pclk0) begin
          state_nxt = S_LOAD;
          idx_nxt   = 5'd0;
        end
      end
      S_LOAD: begin
        if (pclk0) begin
          if (idx == LAST_IDX) begin
`ifdef MARIA_LOADER_WSYNC_EN
            state_nxt = S_SYNC;
`else
            state_nxt = S_REL;
`endif
          end else begin
            idx_nxt = idx + 5'd1;
          end
        end
      end
`ifdef MARIA_LOADER_WSYNC_EN
      S_SYNC: begin
        if (pclk0) state_nxt = S_WAIT;
      end
      // Bus outputs are identical in WAIT and REL, so leaving on ready
      // without a strobe does not move the bus off the pclk0 grid.
      S_WAIT: begin
        if (bus.ready) state_nxt = S_REL;
      end
`endif
      S_REL: begin
        if (pclk0) begin
          state_nxt = S_IDLE;
          idx_nxt   = 5'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = 5'd0;
      end
    endcase
  end

  // Output logic: computes the next bus values. Default is to hold, so the
  // bus only moves on the strobes that advance the sequence.
  always_comb begin
    ab_nxt    = ab_q;
    db_nxt    = db_q;
    we_b_nxt  = we_b_q;
    drive_nxt = drive_q;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        ab_nxt    = 8'h00;
        db_nxt    = 8'h00;
        we_b_nxt  = 1'b1;
        drive_nxt = 1'b0;
      end
      S_ARM: begin
        if (pclk0) begin
          ab_nxt    = item_addr(idx_nxt);
          db_nxt    = snap[idx_nxt];
          we_b_nxt  = 1'b0;
          drive_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        if (pclk0) begin
          if (idx == LAST_IDX) begin
`ifdef MARIA_LOADER_WSYNC_EN
            ab_nxt   = WSYNC_ADDR;
            db_nxt   = 8'h00;
            we_b_nxt = 1'b0;
`else
            // CTRL has been latched; end the write but keep the bus one
            // more strobe so the release is clean.
            we_b_nxt = 1'b1;
`endif
          end else begin
            ab_nxt = item_addr(idx_nxt);
            db_nxt = snap[idx_nxt];
          end
        end
      end
`ifdef MARIA_LOADER_WSYNC_EN
      S_SYNC: begin
        if (pclk0) we_b_nxt = 1'b1;
      end
      S_WAIT: begin
      end
`endif
      S_REL: begin
        if (pclk0) begin
          ab_nxt    = 8'h00;
          db_nxt    = 8'h00;
          we_b_nxt  = 1'b1;
          drive_nxt = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        ab_nxt    = 8'h00;
        db_nxt    = 8'h00;
        we_b_nxt  = 1'b1;
        drive_nxt = 1'b0;
      end
    endcase
  end

  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign bus.AB       = {8'h00, ab_q};
  assign bus.DB_out   = db_q;
  assign bus.we_b     = we_b_q;
  assign bus.drive_AB = drive_q;

endmodule

// File: tb/tb_maria_reg_loader.sv
// ---------------------------------------------------------------------------
// tb_maria_reg_loader
//
// Directed bench for maria_reg_loader. A bus monitor captures every write
// the MARIA decoder would latch (strobe edge with the bus owned and we_b
// low) and compares the log against hand-computed address/data tables.
// ---------------------------------------------------------------------------
module tb_maria_reg_loader;

`ifdef MARIA_LOADER_WSYNC_EN
  localparam int NWR = 30;
`else
  localparam int NWR = 29;
`endif

  logic             sysclock = 1'b0;
  logic             reset;
  logic             start;
  logic [24:0][7:0] img_color;
  logic [15:0]      img_zp;
  logic [7:0]       img_char_base;
  logic [7:0]       img_ctrl;
  logic             busy;
  logic             done;

  maria_reg_loader_if bus ();

  maria_reg_loader dut (
    .sysclock      (sysclock),
    .reset         (reset),
    .start         (start),
    .img_color     (img_color),
    .img_zp        (img_zp),
    .img_char_base (img_char_base),
    .img_ctrl      (img_ctrl),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 sysclock = ~sysclock;

  // Expected write order for the default image (colors 0x10+i, zp 0x1830,
  // char_base 0xA0, ctrl 0x43).
  logic [7:0] expAddr [29] = '{
    8'h20, 8'h21, 8'h22, 8'h23, 8'h25, 8'h26, 8'h27, 8'h29, 8'h2A, 8'h2B,
    8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
    8'h36, 8'h37, 8'h39, 8'h3A, 8'h3B, 8'h3D, 8'h3E, 8'h3F, 8'h3C};
  logic [7:0] expData [29] = '{
    8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
    8'h18, 8'h1A, 8'h1B, 8'h1C, 8'h30, 8'h1D, 8'h1E, 8'h1F, 8'hA0, 8'h20,
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h43};

  // pclk0 strobe generator: high one cycle in every pclkDiv cycles.
  int pclkDiv = 4;
  int pclkCnt = 0;
  always @(negedge sysclock) begin
    if (pclkCnt >= pclkDiv - 1) begin
      pclkCnt   = 0;
      bus.pclk0 = 1'b1;
    end else begin
      pclkCnt++;
      bus.pclk0 = 1'b0;
    end
  end

  // Bus monitor and latency counters.
  int          wrCnt = 0;
  logic [23:0] wrLog [256];
  int          wrCyc [256];
  int          doneCnt = 0;
  int          strobeCnt = 0;
  int          cycCnt = 0;
  int          doneStrobe = 0;
  int          doneCyc = 0;
  int          globalCyc = 0;

  always @(posedge sysclock) begin
    globalCyc++;
    if (done) begin
      doneCnt++;
      doneStrobe = strobeCnt;
      doneCyc    = cycCnt;
    end
    if (!busy) begin
      strobeCnt = 0;
      cycCnt    = 0;
    end else begin
      cycCnt++;
      if (bus.pclk0) strobeCnt++;
    end
    if (bus.pclk0 && bus.drive_AB && !bus.we_b && wrCnt < 256) begin
      wrLog[wrCnt] = {bus.AB, bus.DB_out};
      wrCyc[wrCnt] = globalCyc;
      wrCnt++;
    end
  end

  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sysclock);
    #1;
  endtask

  // Default image, or every image byte forced to fill when isDefault is 0.
  task automatic applyStimulus(input bit isDefault, input logic [7:0] fill);
    for (int i = 0; i < 25; i++) img_color[i] = isDefault ? 8'(8'h10 + i) : fill;
    img_zp        = isDefault ? 16'h1830 : {fill, fill};
    img_char_base = isDefault ? 8'hA0 : fill;
    img_ctrl      = isDefault ? 8'h43 : fill;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int d0;
    d0 = doneCnt;
    for (int c = 0; c < 400 && doneCnt == d0; c++) tick();
    checkOutput(tag, 32'(doneCnt != d0), 1);
  endtask

  task automatic waitAddr(input logic [7:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.drive_AB && bus.AB[7:0] == a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(tag, 32'(found), 1);
  endtask

  initial begin
    int base;
    int dBase;
    int hits;
    int strobes;

    reset     = 1'b1;
    start     = 1'b0;
    bus.ready = 1'b1;
    applyStimulus(1'b1, 8'h00);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst drive_AB", 32'(bus.drive_AB), 0);
    checkOutput("rst we_b", 32'(bus.we_b), 1);
    checkOutput("rst AB", 32'(bus.AB), 0);
    checkOutput("rst DB_out", 32'(bus.DB_out), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst done", 32'(done), 0);

    $display("[TB] default load with snapshot overwrite");
    base  = wrCnt;
    dBase = doneCnt;
    pulseStart();
    tick();
    applyStimulus(1'b0, 8'hFF);
    waitDone("load done");
    checkOutput("load count", 32'(wrCnt - base), NWR);
    for (int i = 0; i < 29; i++)
      checkOutput($sformatf("load item %0d", i), 32'(wrLog[base + i]),
                  {8'h00, 8'h00, expAddr[i], expData[i]});
    checkOutput("load last ctrl", 32'(wrLog[base + 28]), 32'h003C43);
    hits = 0;
    for (int i = 0; i < 29; i++)
      if (wrLog[base + i][15:8] == 8'h24 || wrLog[base + i][15:8] == 8'h28) hits++;
    checkOutput("load holes", 32'(hits), 0);
`ifndef MARIA_LOADER_WSYNC_EN
    checkOutput("load done strobe", 32'(doneStrobe), 31);
`else
    checkOutput("load wsync", 32'(wrLog[base + 29]), 32'h002400);
`endif
    checkOutput("load done count", 32'(doneCnt - dBase), 1);
    checkOutput("load busy after", 32'(busy), 0);

    $display("[TB] reset at item 10");
    applyStimulus(1'b1, 8'h00);
    pulseStart();
    waitAddr(8'h2C, "reach item 10");
    dBase = doneCnt;
    reset = 1'b1;
    tick();
    checkOutput("midrst drive_AB", 32'(bus.drive_AB), 0);
    checkOutput("midrst we_b", 32'(bus.we_b), 1);
    checkOutput("midrst AB", 32'(bus.AB), 0);
    checkOutput("midrst busy", 32'(busy), 0);
    checkOutput("midrst done", 32'(done), 0);
    reset = 1'b0;
    repeat (20) tick();
    checkOutput("midrst no done", 32'(doneCnt - dBase), 0);
    base = wrCnt;
    pulseStart();
    waitDone("reload done");
    checkOutput("reload first", 32'(wrLog[base]), 32'h002010);
    checkOutput("reload count", 32'(wrCnt - base), NWR);

    $display("[TB] start while busy");
    base  = wrCnt;
    dBase = doneCnt;
    pulseStart();
    waitAddr(8'h26, "reach item 5");
    pulseStart();
    waitAddr(8'h36, "reach item 20");
    pulseStart();
    waitDone("busy done");
    repeat (150) tick();
    checkOutput("busy done count", 32'(doneCnt - dBase), 1);
    checkOutput("busy write count", 32'(wrCnt - base), NWR);

    $display("[TB] continuous pclk0");
    pclkDiv = 1;
    repeat (4) tick();
    base = wrCnt;
    pulseStart();
    waitDone("cont done");
    checkOutput("cont count", 32'(wrCnt - base), NWR);
    checkOutput("cont spacing", 32'(wrCyc[base + 28] - wrCyc[base]), 28);
`ifndef MARIA_LOADER_WSYNC_EN
    checkOutput("cont done cycle", 32'(doneCyc), 31);
`endif

    $display("[TB] start held high");
    start = 1'b1;
    waitDone("held first done");
    checkOutput("held retrigger busy", 32'(busy), 1);
    start = 1'b0;
    waitDone("held second done");

`ifdef MARIA_LOADER_WSYNC_EN
    $display("[TB] wsync wait");
    pclkDiv   = 4;
    bus.ready = 1'b0;
    repeat (4) tick();
    base = wrCnt;
    pulseStart();
    hits = 0;
    for (int c = 0; c < 400; c++) begin
      if (bus.drive_AB && bus.we_b && bus.AB[7:0] == 8'h24) begin
        hits = 1;
        break;
      end
      tick();
    end
    checkOutput("wsync reach wait", 32'(hits), 1);
    checkOutput("wsync ctrl", 32'(wrLog[base + 28]), 32'h003C43);
    checkOutput("wsync write", 32'(wrLog[base + 29]), 32'h002400);
    repeat (50) tick();
    checkOutput("wsync hold drive", 32'(bus.drive_AB), 1);
    checkOutput("wsync hold busy", 32'(busy), 1);
    for (int c = 0; c < 8 && !bus.pclk0; c++) tick();
    bus.ready = 1'b1;
    strobes = 0;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.pclk0) strobes++;
      if (done) begin
        hits = 1;
        break;
      end
    end
    checkOutput("wsync done seen", 32'(hits), 1);
    checkOutput("wsync done strobe", 32'(strobes), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
